bike_orient_ctrl: RTL and testbench
===================================

Name: bike_orient_ctrl

Overview:
- Per-bike steering/orientation controller for the lightbike game, generalised to NUM_BIKES channels and a parametrised screen width.
- Captures debounced direction-button presses into a pending-turn buffer and commits them only on the frame tick.
- Blocks 180-degree reversals and accepts a processor override load of a movement delta.
- Outputs both the 2-bit orientation and the signed per-frame address delta consumed by the bike position logic.

Parameters:
- NUM_BIKES, 2, number of independent bike channels.
- SCREEN_W, 640, pixels per row; magnitude of the vertical address delta.
- DELTA_W, 32, width of the signed movement delta.

Ports:
- clock  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- tick  in  1  one-cycle frame-advance strobe, shared by all bikes.
- btn_up  in  NUM_BIKES  raw up button, one bit per bike.
- btn_left  in  NUM_BIKES  raw left button, one bit per bike.
- btn_down  in  NUM_BIKES  raw down button, one bit per bike.
- btn_right  in  NUM_BIKES  raw right button, one bit per bike.
- load_en  in  NUM_BIKES  processor override strobe, one bit per bike.
- load_delta  in  NUM_BIKES*DELTA_W  override delta; bike i occupies slice [i*DELTA_W +: DELTA_W].
- orient  out  2*NUM_BIKES  current orientation per bike.
- delta  out  NUM_BIKES*DELTA_W  signed movement delta per bike.
- turn_done  out  NUM_BIKES  one-cycle pulse when a turn commits.
- rev_blocked  out  NUM_BIKES  one-cycle pulse when a reversal is dropped.
- load_bad  out  NUM_BIKES  one-cycle pulse when load_delta is unrecognised.

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-low.
- Orientation encoding: UP=00, LEFT=01, DOWN=10, RIGHT=11.
- Delta mapping: UP=-SCREEN_W, LEFT=-1, DOWN=+SCREEN_W, RIGHT=+1, two's complement, DELTA_W bits.
- delta is combinational from the orientation register.
- Opposite pairs: UP<->DOWN, LEFT<->RIGHT (opposite = orient XOR 2'b10).
- Reset values:
  - Even-index bikes: RIGHT. Odd-index bikes: LEFT.
  - Pending buffer empty.
  - Synchroniser and edge registers 0.
  - All pulse outputs 0.
- Button path: each button goes through a 2-flop synchroniser, then rising-edge detect.
  - A button high from cycle N produces the edge in cycle N+2.
  - The pending buffer is valid from N+3.
  - Holding a button produces only one edge.
- Simultaneous edges on one bike: priority UP > LEFT > DOWN > RIGHT; the others are discarded.
- Pending buffer: one entry (valid + 2-bit dir) per bike. A new edge overwrites any uncommitted entry (last press wins).
- On tick with pending valid:
  - dir == opposite(orient): orient unchanged, pending cleared, rev_blocked pulses next cycle.
  - dir == orient: pending cleared, no pulse.
  - Otherwise: orient <= dir, pending cleared, turn_done pulses in the cycle after the tick. The new orient/delta are visible the cycle after the tick.
- Tick and a new edge in the same cycle: the tick acts on the old pending entry, and the new edge is stored as pending afterwards.
- load_en:
  - Has priority over tick in the same cycle.
  - Decodes load_delta: -1 gives LEFT, +SCREEN_W gives DOWN, +1 gives RIGHT, -SCREEN_W gives UP.
  - Any other value gives UP and pulses load_bad.
  - Clears pending. No reversal check, no turn_done.
- Channel independence: channels never interact; identical events on different bikes resolve independently.
- Reset mid-operation: all state returns to reset values immediately; pulses deassert asynchronously.

Decomposition:
- Package bike_orient_pkg:
  - Constants ORIENT_UP/LEFT/DOWN/RIGHT.
  - Opposite-direction function.
  - Orientation-to-delta and delta-to-orientation functions, parametrised by SCREEN_W.
- Sub-module bike_orient_channel: one bike's synchroniser, edge detect, pending buffer, orientation register and pulses. Top level is a generate loop over NUM_BIKES plus port slicing.

Test Plan:
- Reset release, no inputs -> orient = {01,11} (bike1 LEFT, bike0 RIGHT); delta0 = 32'h00000001; delta1 = 32'hFFFFFFFF; all pulses 0.
- Bike0 btn_up held from cycle 10, tick at cycle 20 -> pending valid at 13; at 21 orient0 = 00, delta0 = 32'hFFFFFD80 (-640), turn_done[0] = 1 for one cycle.
- Bike0 (RIGHT) btn_left, then tick -> orient0 stays 11; rev_blocked[0] pulses; a second tick without a press does nothing.
- Bike1 btn_down edge followed by btn_up edge before tick, then tick -> UP commits (last wins); orient1 = 00.
- Same cycle: load_en[0] with load_delta = 640 and tick with pending LEFT -> orient0 = 10, delta0 = 640, pending cleared, no turn_done.
- load_delta = 7 on bike1 -> orient1 = 00, load_bad[1] pulses; assert resetn low mid-turn -> immediate return to reset values.

Source files
------------

// File: rtl/bike_orient_pkg.sv
// Shared orientation encoding, pending-turn record and delta conversion helpers
// for the lightbike steering controller.
package bike_orient_pkg;

  localparam logic [1:0] ORIENT_UP    = 2'b00;
  localparam logic [1:0] ORIENT_LEFT  = 2'b01;
  localparam logic [1:0] ORIENT_DOWN  = 2'b10;
  localparam logic [1:0] ORIENT_RIGHT = 2'b11;

  // Button vectors are indexed by orientation code: [0]=up [1]=left [2]=down [3]=right.
  localparam int NUM_DIRS = 4;

  typedef struct packed {
    logic       valid;
    logic [1:0] dir;
  } pend_t;

  typedef struct packed {
    logic       ok;
    logic [1:0] dir;
  } decode_t;

  // Opposite pairs differ only in the upper bit of the encoding.
  function automatic logic [1:0] opposite(input logic [1:0] o);
    return o ^ 2'b10;
  endfunction

  // Per-frame address delta for an orientation; callers size the result.
  function automatic longint orient_to_delta(input logic [1:0] o, input int screen_w);
    longint d;
    case (o)
      ORIENT_UP:    d = -longint'(screen_w);
      ORIENT_LEFT:  d = -64'sd1;
      ORIENT_DOWN:  d = longint'(screen_w);
      default:      d = 64'sd1;
    endcase
    return d;
  endfunction

  // Inverse mapping used by the processor override; unknown deltas fall back to UP.
  function automatic decode_t delta_to_orient(input longint d, input int screen_w);
    decode_t r;
    r.ok  = 1'b1;
    r.dir = ORIENT_UP;
    if (d == -64'sd1)                   r.dir = ORIENT_LEFT;
    else if (d == longint'(screen_w))   r.dir = ORIENT_DOWN;
    else if (d == 64'sd1)               r.dir = ORIENT_RIGHT;
    else if (d == -longint'(screen_w))  r.dir = ORIENT_UP;
    else                                r.ok  = 1'b0;
    return r;
  endfunction

  // Resolves simultaneous presses: UP > LEFT > DOWN > RIGHT.
  function automatic logic [1:0] first_press(input logic [NUM_DIRS-1:0] e);
    logic [1:0] dir;
    if (e[0])      dir = ORIENT_UP;
    else if (e[1]) dir = ORIENT_LEFT;
    else if (e[2]) dir = ORIENT_DOWN;
    else           dir = ORIENT_RIGHT;
    return dir;
  endfunction

endpackage

// File: rtl/bike_orient_channel.sv
// One bike: button synchronisers and edge detect, single-entry pending turn,
// orientation register committed on the frame tick, and event pulses.
module bike_orient_channel
  import bike_orient_pkg::*;
#(
  parameter int         SCREEN_W     = 640,
  parameter int         DELTA_W      = 32,
  parameter logic [1:0] RESET_ORIENT = ORIENT_RIGHT
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                tick_i,
  input  logic [NUM_DIRS-1:0] btn_i,
  input  logic                load_en_i,
  input  logic [DELTA_W-1:0]  load_delta_i,
  output logic [1:0]          orient_o,
  output logic [DELTA_W-1:0]  delta_o,
  output logic                turn_done_o,
  output logic                rev_blocked_o,
  output logic                load_bad_o
);

  logic [NUM_DIRS-1:0] sync1_q, sync2_q, prev_q;
  logic [NUM_DIRS-1:0] btn_rise;

  pend_t      pend_q, pend_d;
  logic [1:0] orient_q, orient_d;
  logic       turn_q, turn_d;
  logic       rev_q, rev_d;
  logic       bad_q, bad_d;
  decode_t    load_dec;

  assign btn_rise = sync2_q & ~prev_q;
  assign load_dec = delta_to_orient(longint'(signed'(load_delta_i)), SCREEN_W);

  // Two-flop synchroniser plus previous-value register for rising-edge detect.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Orientation, pending entry and registered event pulses.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      orient_q <= RESET_ORIENT;
      pend_q   <= '0;
      turn_q   <= 1'b0;
      rev_q    <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      orient_q <= orient_d;
      pend_q   <= pend_d;
      turn_q   <= turn_d;
      rev_q    <= rev_d;
      bad_q    <= bad_d;
    end
  end

  // Override beats tick; a press in the same cycle as either is stored afterwards.
  always_comb begin
    orient_d = orient_q;
    pend_d   = pend_q;
    turn_d   = 1'b0;
    rev_d    = 1'b0;
    bad_d    = 1'b0;

    if (load_en_i) begin
      orient_d     = load_dec.dir;
      bad_d        = ~load_dec.ok;
      pend_d.valid = 1'b0;
    end else if (tick_i && pend_q.valid) begin
      pend_d.valid = 1'b0;
      if (pend_q.dir == opposite(orient_q)) begin
        rev_d = 1'b1;
      end else if (pend_q.dir != orient_q) begin
        orient_d = pend_q.dir;
        turn_d   = 1'b1;
      end
    end

    if (|btn_rise) begin
      pend_d.valid = 1'b1;
      pend_d.dir   = first_press(btn_rise);
    end
  end

  assign orient_o      = orient_q;
  assign delta_o       = DELTA_W'(orient_to_delta(orient_q, SCREEN_W));
  assign turn_done_o   = turn_q;
  assign rev_blocked_o = rev_q;
  assign load_bad_o    = bad_q;

endmodule

// File: rtl/bike_orient_ctrl.sv
// Lightbike steering controller: NUM_BIKES independent orientation channels
// sharing one frame tick. Even bikes start RIGHT, odd bikes start LEFT.
module bike_orient_ctrl
  import bike_orient_pkg::*;
#(
  parameter int NUM_BIKES = 2,
  parameter int SCREEN_W  = 640,
  parameter int DELTA_W   = 32
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         tick,
  input  logic [NUM_BIKES-1:0]         btn_up,
  input  logic [NUM_BIKES-1:0]         btn_left,
  input  logic [NUM_BIKES-1:0]         btn_down,
  input  logic [NUM_BIKES-1:0]         btn_right,
  input  logic [NUM_BIKES-1:0]         load_en,
  input  logic [NUM_BIKES*DELTA_W-1:0] load_delta,
  output logic [2*NUM_BIKES-1:0]       orient,
  output logic [NUM_BIKES*DELTA_W-1:0] delta,
  output logic [NUM_BIKES-1:0]         turn_done,
  output logic [NUM_BIKES-1:0]         rev_blocked,
  output logic [NUM_BIKES-1:0]         load_bad
);

  for (genvar i = 0; i < NUM_BIKES; i++) begin : g_bike
    bike_orient_channel #(
      .SCREEN_W     (SCREEN_W),
      .DELTA_W      (DELTA_W),
      .RESET_ORIENT ((i % 2 == 0) ? ORIENT_RIGHT : ORIENT_LEFT)
    ) u_channel (
      .clock         (clock),
      .resetn        (resetn),
      .tick_i        (tick),
      .btn_i         ({btn_right[i], btn_down[i], btn_left[i], btn_up[i]}),
      .load_en_i     (load_en[i]),
      .load_delta_i  (load_delta[i*DELTA_W +: DELTA_W]),
      .orient_o      (orient[2*i +: 2]),
      .delta_o       (delta[i*DELTA_W +: DELTA_W]),
      .turn_done_o   (turn_done[i]),
      .rev_blocked_o (rev_blocked[i]),
      .load_bad_o    (load_bad[i])
    );
  end

endmodule

// File: tb/tb_bike_orient_ctrl.sv
// Bench for bike_orient_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the steering rules.
module tb_bike_orient_ctrl;

  localparam int NB = 2;
  localparam int SW = 640;
  localparam int DW = 32;

  logic               clock = 1'b0;
  logic               resetn = 1'b0;
  logic               tick = 1'b0;
  logic [NB-1:0]      btn_up = '0, btn_left = '0, btn_down = '0, btn_right = '0;
  logic [NB-1:0]      load_en = '0;
  logic [NB*DW-1:0]   load_delta = '0;
  logic [2*NB-1:0]    orient;
  logic [NB*DW-1:0]   delta;
  logic [NB-1:0]      turn_done, rev_blocked, load_bad;

  int checks = 0;
  int errors = 0;

  bike_orient_ctrl #(.NUM_BIKES(NB), .SCREEN_W(SW), .DELTA_W(DW)) dut (
    .clock(clock), .resetn(resetn), .tick(tick),
    .btn_up(btn_up), .btn_left(btn_left), .btn_down(btn_down), .btn_right(btn_right),
    .load_en(load_en), .load_delta(load_delta),
    .orient(orient), .delta(delta), .turn_done(turn_done),
    .rev_blocked(rev_blocked), .load_bad(load_bad)
  );

  always #5 clock = ~clock;

  // Model: orientation, pending turn, and raw input history (newest first).
  logic [1:0]    m_or [NB];
  logic          m_pv [NB];
  logic [1:0]    m_pd [NB];
  logic [3:0]    m_hist [NB][3];
  logic [NB-1:0] m_td, m_rb, m_lb;

  function automatic logic [DW-1:0] exp_delta(input logic [1:0] o);
    int v;
    case (o)
      2'd0:    v = -SW;
      2'd1:    v = -1;
      2'd2:    v = SW;
      default: v = 1;
    endcase
    return v;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      m_or[b] = (b % 2 == 0) ? 2'd3 : 2'd1;
      m_pv[b] = 1'b0;
      m_pd[b] = 2'd0;
      for (int k = 0; k < 3; k++) m_hist[b][k] = 4'd0;
    end
    m_td = '0; m_rb = '0; m_lb = '0;
  endtask

  // A press high in cycle N is seen as an edge two cycles later.
  task automatic model_clock();
    for (int b = 0; b < NB; b++) begin
      logic [3:0] cur, rise;
      int val;
      cur  = {btn_right[b], btn_down[b], btn_left[b], btn_up[b]};
      rise = m_hist[b][1] & ~m_hist[b][2];
      val  = int'(load_delta[b*DW +: DW]);
      m_td[b] = 1'b0; m_rb[b] = 1'b0; m_lb[b] = 1'b0;
      if (load_en[b]) begin
        m_pv[b] = 1'b0;
        if (val == -1)       m_or[b] = 2'd1;
        else if (val == SW)  m_or[b] = 2'd2;
        else if (val == 1)   m_or[b] = 2'd3;
        else if (val == -SW) m_or[b] = 2'd0;
        else begin
          m_or[b] = 2'd0;
          m_lb[b] = 1'b1;
        end
      end else if (tick && m_pv[b]) begin
        m_pv[b] = 1'b0;
        if ((m_pd[b] == 2'd0 && m_or[b] == 2'd2) || (m_pd[b] == 2'd2 && m_or[b] == 2'd0) ||
            (m_pd[b] == 2'd1 && m_or[b] == 2'd3) || (m_pd[b] == 2'd3 && m_or[b] == 2'd1))
          m_rb[b] = 1'b1;
        else if (m_pd[b] != m_or[b]) begin
          m_or[b] = m_pd[b];
          m_td[b] = 1'b1;
        end
      end
      if (rise != 4'd0) begin
        m_pv[b] = 1'b1;
        if (rise[0])      m_pd[b] = 2'd0;
        else if (rise[1]) m_pd[b] = 2'd1;
        else if (rise[2]) m_pd[b] = 2'd2;
        else              m_pd[b] = 2'd3;
      end
      m_hist[b][2] = m_hist[b][1];
      m_hist[b][1] = m_hist[b][0];
      m_hist[b][0] = cur;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    for (int b = 0; b < NB; b++) begin
      chk($sformatf("orient%0d", b), 64'(orient[2*b +: 2]), 64'(m_or[b]));
      chk($sformatf("delta%0d", b), 64'(delta[b*DW +: DW]), 64'(exp_delta(m_or[b])));
    end
    chk("turn_done", 64'(turn_done), 64'(m_td));
    chk("rev_blocked", 64'(rev_blocked), 64'(m_rb));
    chk("load_bad", 64'(load_bad), 64'(m_lb));
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      model_clock();
      #1;
      check_outputs();
    end
  endtask

  initial begin
    model_reset();
    #12;
    check_outputs();
    chk("reset_orient", 64'(orient), 64'h7);
    chk("reset_delta0", 64'(delta[31:0]), 64'h00000001);
    chk("reset_delta1", 64'(delta[63:32]), 64'hFFFFFFFF);
    @(negedge clock);
    resetn = 1'b1;
    step(3);

    // Bike0 UP held, tick ten cycles later.
    btn_up[0] = 1'b1;
    step(10);
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("up_orient0", 64'(orient[1:0]), 64'h0);
    chk("up_delta0", 64'(delta[31:0]), 64'hFFFFFD80);
    chk("up_turn_done", 64'(turn_done[0]), 64'h1);
    step();
    chk("up_turn_done_once", 64'(turn_done[0]), 64'h0);
    btn_up[0] = 1'b0;
    step(3);

    // Bike0 back to RIGHT by override, then a blocked LEFT reversal.
    load_en[0] = 1'b1;
    load_delta[31:0] = 32'd1;
    step();
    load_en[0] = 1'b0;
    btn_left[0] = 1'b1;
    step(4);
    btn_left[0] = 1'b0;
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("rev_orient0", 64'(orient[1:0]), 64'h3);
    chk("rev_pulse", 64'(rev_blocked[0]), 64'h1);
    step();
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("idle_tick_orient0", 64'(orient[1:0]), 64'h3);
    chk("idle_tick_pulses", 64'({turn_done[0], rev_blocked[0]}), 64'h0);

    // Bike1 DOWN then UP before the tick: last press wins.
    btn_down[1] = 1'b1;
    step(2);
    btn_down[1] = 1'b0;
    step();
    btn_up[1] = 1'b1;
    step(4);
    btn_up[1] = 1'b0;
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("last_wins_orient1", 64'(orient[3:2]), 64'h0);
    step(2);

    // Override and tick together with pending LEFT on bike0.
    btn_left[0] = 1'b1;
    step(4);
    btn_left[0] = 1'b0;
    load_en[0] = 1'b1;
    load_delta[31:0] = 32'd640;
    tick = 1'b1;
    step();
    load_en[0] = 1'b0;
    tick = 1'b0;
    chk("load_tick_orient0", 64'(orient[1:0]), 64'h2);
    chk("load_tick_delta0", 64'(delta[31:0]), 64'd640);
    chk("load_tick_no_turn", 64'(turn_done[0]), 64'h0);
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("load_cleared_pend", 64'(orient[1:0]), 64'h2);

    // Unrecognised override delta on bike1.
    load_en[1] = 1'b1;
    load_delta[63:32] = 32'd7;
    step();
    load_en[1] = 1'b0;
    chk("bad_orient1", 64'(orient[3:2]), 64'h0);
    chk("bad_pulse", 64'(load_bad[1]), 64'h1);
    step();

    // Reset in the cycle a turn commits.
    btn_right[0] = 1'b1;
    step(4);
    btn_right[0] = 1'b0;
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("pre_reset_turn", 64'(turn_done[0]), 64'h1);
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clock);
    resetn = 1'b1;
    step(2);

    // Random traffic.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int b = 0; b < NB; b++) begin
        if ($urandom_range(0, 7) == 0) btn_up[b]    = ~btn_up[b];
        if ($urandom_range(0, 7) == 0) btn_left[b]  = ~btn_left[b];
        if ($urandom_range(0, 7) == 0) btn_down[b]  = ~btn_down[b];
        if ($urandom_range(0, 7) == 0) btn_right[b] = ~btn_right[b];
        load_en[b] = ($urandom_range(0, 19) == 0);
        case ($urandom_range(0, 4))
          0:       load_delta[b*DW +: DW] = 32'hFFFFFFFF;
          1:       load_delta[b*DW +: DW] = 32'd1;
          2:       load_delta[b*DW +: DW] = 32'd640;
          3:       load_delta[b*DW +: DW] = 32'hFFFFFD80;
          default: load_delta[b*DW +: DW] = $urandom;
        endcase
      end
      tick = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
